// File: rtl/interval_capture.sv
// Measures clk cycles between a start and a stop pulse and offers each result
// on a valid/ready output; measurements still open at TIMEOUT are aborted and flagged.
module interval_capture #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 200
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             start_pulse,
    input  logic             stop_pulse,
    output logic [CNT_W-1:0] meas_value,
    output logic             meas_timeout,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic             busy,
    output logic             overrun,
    output logic [1:0]       fsm_state
);

    if (TIMEOUT < 1 || TIMEOUT > (2 ** CNT_W) - 1) begin : g_bad_timeout
        $error("interval_capture: TIMEOUT must lie in 1 .. 2**CNT_W-1");
    end

    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MEASURE = 2'd1,
        S_HOLD    = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;

    // cnt stays at or below TIMEOUT-1, so the increment cannot wrap.
    assign cnt_inc = cnt + ONE;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            meas_value   <= '0;
            meas_timeout <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            overrun <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_pulse) begin
                        cnt   <= '0;
                        state <= S_MEASURE;
                    end
                end
                S_MEASURE: begin
                    if (stop_pulse) begin
                        meas_value   <= cnt_inc;
                        meas_timeout <= 1'b0;
                        state        <= S_HOLD;
                    end else if (cnt_inc == TIMEOUT_V) begin
                        meas_value   <= TIMEOUT_V;
                        meas_timeout <= 1'b1;
                        state        <= S_HOLD;
                    end else if (start_pulse) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                S_HOLD: begin
                    // A result transfers on any edge where meas_valid and meas_ready
                    // are both high; meas_valid never drops without that transfer.
                    if (meas_ready) begin
                        if (start_pulse) begin
                            cnt   <= '0;
                            state <= S_MEASURE;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else if (start_pulse) begin
                        overrun <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign meas_valid = (state == S_HOLD);
    assign busy       = (state != S_IDLE);
    assign fsm_state  = state;

endmodule

// File: tb/tb_interval_capture.sv
// Directed bench for interval_capture: hand-computed intervals, timeout,
// retrigger, overrun during a stalled result and asynchronous reset.
module tb_interval_capture;

    logic       clk;
    logic       areset;
    logic       start_pulse;
    logic       stop_pulse;
    logic [7:0] meas_value;
    logic       meas_timeout;
    logic       meas_valid;
    logic       meas_ready;
    logic       busy;
    logic       overrun;
    logic [1:0] fsm_state;

    int n_checks = 0;
    int n_errors = 0;

    interval_capture #(.CNT_W(8), .TIMEOUT(200)) dut (
        .clk          (clk),
        .areset       (areset),
        .start_pulse  (start_pulse),
        .stop_pulse   (stop_pulse),
        .meas_value   (meas_value),
        .meas_timeout (meas_timeout),
        .meas_valid   (meas_valid),
        .meas_ready   (meas_ready),
        .busy         (busy),
        .overrun      (overrun),
        .fsm_state    (fsm_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        areset      = 1'b1;
        start_pulse = 1'b0;
        stop_pulse  = 1'b0;
        meas_ready  = 1'b1;
        #3;
        check("rst_valid",   meas_valid,   0);
        check("rst_value",   meas_value,   0);
        check("rst_timeout", meas_timeout, 0);
        check("rst_busy",    busy,         0);
        check("rst_overrun", overrun,      0);
        check("rst_state",   fsm_state,    0);
        #9 areset = 1'b0;
        tick();

        // Interval of 7 with meas_ready held high.
        start_pulse = 1'b1; tick(); start_pulse = 1'b0;
        check("t1_busy", busy, 1);
        ticks(6);
        check("t1_no_valid", meas_valid, 0);
        stop_pulse = 1'b1; tick(); stop_pulse = 1'b0;
        check("t1_valid",   meas_valid,   1);
        check("t1_value",   meas_value,   7);
        check("t1_timeout", meas_timeout, 0);
        tick();
        check("t1_valid_drop", meas_valid, 0);
        check("t1_busy_drop",  busy,       0);

        // Minimum interval of 1.
        start_pulse = 1'b1; tick(); start_pulse = 1'b0;
        stop_pulse = 1'b1; tick(); stop_pulse = 1'b0;
        check("t2_min_valid", meas_valid, 1);
        check("t2_min_value", meas_value, 1);
        tick();

        // Start and stop together in IDLE: start taken, stop ignored.
        start_pulse = 1'b1; stop_pulse = 1'b1; tick();
        start_pulse = 1'b0; stop_pulse = 1'b0;
        check("t2_idle_both_busy",  busy,       1);
        check("t2_idle_both_valid", meas_valid, 0);
        ticks(2);
        stop_pulse = 1'b1; tick(); stop_pulse = 1'b0;
        check("t2_value3", meas_value, 3);
        check("t2_valid3", meas_valid, 1);
        tick();

        // Timeout with downstream stalled, late stop ignored in HOLD.
        meas_ready = 1'b0;
        start_pulse = 1'b1; tick(); start_pulse = 1'b0;
        ticks(199);
        check("t3_pre_timeout_valid", meas_valid, 0);
        tick();
        check("t3_to_valid",   meas_valid,   1);
        check("t3_to_value",   meas_value,   200);
        check("t3_to_flag",    meas_timeout, 1);
        stop_pulse = 1'b1; tick(); stop_pulse = 1'b0;
        check("t3_late_stop_value", meas_value,   200);
        check("t3_late_stop_flag",  meas_timeout, 1);
        check("t3_late_stop_valid", meas_valid,   1);
        meas_ready = 1'b1; tick();
        check("t3_handshake_valid", meas_valid,   0);
        check("t3_value_kept",      meas_value,   200);
        check("t3_flag_kept",       meas_timeout, 1);

        // Retrigger after 5 cycles, stop 4 cycles later.
        start_pulse = 1'b1; tick(); start_pulse = 1'b0;
        ticks(4);
        start_pulse = 1'b1; tick(); start_pulse = 1'b0;
        ticks(3);
        check("t4_retrig_busy", busy, 1);
        stop_pulse = 1'b1; tick(); stop_pulse = 1'b0;
        check("t4_retrig_value",   meas_value,   4);
        check("t4_retrig_timeout", meas_timeout, 0);
        tick();

        // Start and stop together in MEASURE: stop wins.
        start_pulse = 1'b1; tick(); start_pulse = 1'b0;
        ticks(2);
        start_pulse = 1'b1; stop_pulse = 1'b1; tick();
        start_pulse = 1'b0; stop_pulse = 1'b0;
        check("t4_both_valid", meas_valid, 1);
        check("t4_both_value", meas_value, 3);
        tick();

        // Stalled result, start dropped in HOLD, then back-to-back start.
        meas_ready = 1'b0;
        start_pulse = 1'b1; tick(); start_pulse = 1'b0;
        ticks(2);
        stop_pulse = 1'b1; tick(); stop_pulse = 1'b0;
        check("t5_valid", meas_valid, 1);
        check("t5_value", meas_value, 3);
        tick();
        check("t5_no_overrun", overrun, 0);
        start_pulse = 1'b1; tick(); start_pulse = 1'b0;
        check("t5_overrun",       overrun,    1);
        check("t5_overrun_value", meas_value, 3);
        tick();
        check("t5_overrun_once", overrun,    0);
        check("t5_still_valid",  meas_valid, 1);
        ticks(3);
        check("t5_stable_value", meas_value, 3);
        meas_ready = 1'b1; start_pulse = 1'b1; tick(); start_pulse = 1'b0;
        check("t5_b2b_valid", meas_valid, 0);
        check("t5_b2b_busy",  busy,       1);
        ticks(4);
        stop_pulse = 1'b1; tick(); stop_pulse = 1'b0;
        check("t5_b2b_value", meas_value, 5);
        check("t5_b2b_done",  meas_valid, 1);
        tick();

        // Asynchronous reset mid-MEASURE with cnt=50.
        start_pulse = 1'b1; tick(); start_pulse = 1'b0;
        ticks(50);
        #2 areset = 1'b1;
        #1;
        check("t6_meas_rst_busy",  busy,       0);
        check("t6_meas_rst_value", meas_value, 0);
        check("t6_meas_rst_valid", meas_valid, 0);
        #2 areset = 1'b0;
        stop_pulse = 1'b1; tick(); stop_pulse = 1'b0;
        check("t6_stop_after_rst_valid", meas_valid, 0);
        check("t6_stop_after_rst_busy",  busy,       0);

        // Asynchronous reset mid-HOLD.
        meas_ready = 1'b0;
        start_pulse = 1'b1; tick(); start_pulse = 1'b0;
        stop_pulse = 1'b1; tick(); stop_pulse = 1'b0;
        check("t6_hold_valid", meas_valid, 1);
        #2 areset = 1'b1;
        #1;
        check("t6_hold_rst_valid",   meas_valid,   0);
        check("t6_hold_rst_value",   meas_value,   0);
        check("t6_hold_rst_timeout", meas_timeout, 0);
        check("t6_hold_rst_busy",    busy,         0);
        #2 areset = 1'b0;
        stop_pulse = 1'b1; tick(); stop_pulse = 1'b0;
        check("t6_hold_stop_valid", meas_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/interval_capture.md
Name: interval_capture

Overview:
- Measures the number of clk cycles between a start pulse and a stop pulse, the inverse of the countdown timer function: it converts elapsed time into a count instead of a count into elapsed time.
- Presents each result on a valid/ready output handshake.
- Flags measurements that exceed a programmable timeout.
- Sits beside the timer/counter blocks in the level-0 practical set; consumes event pulses and feeds a downstream register/logger.

Parameters:
- CNT_W, 8, width of the interval counter and meas_value.
- TIMEOUT, 200, cycle count at which an open measurement is aborted. Must satisfy 1 <= TIMEOUT <= 2^CNT_W-1; elaboration error otherwise.

Ports:
- clk  input  1  clock; all logic on rising edge.
- areset  input  1  reset, asynchronous, active-high.
- start_pulse  input  1  opens a measurement; level sampled each cycle.
- stop_pulse  input  1  closes a measurement; level sampled each cycle.
- meas_value  output  CNT_W  captured interval in cycles; stable while meas_valid=1.
- meas_timeout  output  1  qualifies meas_value: 1 = aborted at TIMEOUT, no stop seen.
- meas_valid  output  1  result available.
- meas_ready  input  1  downstream accepts the result when meas_valid=1.
- busy  output  1  1 in MEASURE or HOLD.
- overrun  output  1  one-cycle pulse when a start_pulse is dropped in HOLD.

Behaviour:
- Reset, asynchronous: state=IDLE, internal cnt=0, meas_value=0, meas_timeout=0, meas_valid=0, busy=0, overrun=0. Reset mid-measurement or mid-HOLD discards all data; the first cycle after release is IDLE.
- All outputs are registered. busy is decoded from registered state.

State machine IDLE / MEASURE / HOLD:
- IDLE, start_pulse=1: cnt<=0, go to MEASURE. stop_pulse in IDLE is ignored, including when it coincides with start_pulse; the start is taken.
- MEASURE, each cycle:
  - If stop_pulse=1: meas_value<=cnt+1, meas_timeout<=0, go to HOLD. Stop wins over a simultaneous start.
  - Else if cnt+1==TIMEOUT: meas_value<=TIMEOUT, meas_timeout<=1, go to HOLD.
  - Else if start_pulse=1: retrigger, cnt<=0, stay in MEASURE.
  - Else cnt<=cnt+1.
- Interval definition: start sampled at edge k and stop sampled at edge k+N gives meas_value=N, with N>=1. Minimum result is 1. cnt never exceeds TIMEOUT-1, so no wrap is possible.
- HOLD: meas_valid=1; meas_value and meas_timeout are held.
  - meas_ready=1 completes the handshake. Next cycle meas_valid=0 and the state goes to IDLE, or to MEASURE with cnt<=0 if start_pulse=1 in the same cycle (back-to-back, no lost start).
  - start_pulse=1 with meas_ready=0: the start is dropped and overrun=1 for the following cycle only.
  - meas_valid never deasserts without a handshake.
- meas_value and meas_timeout keep their last captured values after the handshake. Consumers must qualify them with meas_valid only.
- Latency: meas_valid rises on the edge after the cycle in which stop is sampled, which is the same edge that captures meas_value.

Test Plan:
- Reset, then start at edge 10 and stop at edge 17, meas_ready=1 held -> meas_valid=1 for one cycle, meas_value=7, meas_timeout=0, busy back to 0 one cycle later.
- Start then stop on the next edge -> meas_value=1. Start and stop asserted together in IDLE -> measurement opens; a stop 3 cycles later -> meas_value=3.
- Start with no stop -> after 200 cycles meas_valid=1, meas_value=200, meas_timeout=1. A stop arriving afterwards is ignored in HOLD.
- Start, retrigger start 5 cycles later, stop 4 cycles after that -> meas_value=4. Start and stop together in MEASURE -> the stop is taken.
- Result pending with meas_ready=0 for 6 cycles and a start pulsed during HOLD -> overrun pulses for exactly 1 cycle, meas_value stays stable. Then meas_ready=1 together with start -> next cycle meas_valid=0, busy=1, and a new measurement is counting.
- areset asserted mid-MEASURE (cnt=50) and mid-HOLD -> all outputs 0 immediately. A stop after release produces no result.
